bsg_mcl_axil_host_master: RTL and testbench

//  AXI-Lite master that drives the host-side MMIO FIFOs of the manycore-link AXI-Lite bridge.
//  - TX: serializes 128-bit request packets into four 32-bit writes to the TX data register.
//  - RX: polls the RX occupancy register and reads four 32-bit words back into one 128-bit packet.
//  - Sits host-side (PCIe/shell or testbench); replaces software MMIO polling.

---
 rtl/bsg_mcl_axil_host_master.sv | 93 +++++++++
 tb/tb_bsg_mcl_axil_host_master.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_mcl_axil_host_master.sv
// bsg_mcl_axil_host_master: AXI-Lite master moving 128b packets through the manycore-link bridge MMIO FIFOs.
// Bus vectors use bsg_axil mosi/miso packing (32b addr/data); define BSG_MCL_HOST_TIMEOUT_EN for the response watchdog.
module bsg_mcl_axil_host_master #(
  parameter logic [31:0] axil_base_addr_p      = 32'h0000_0000,
  parameter logic [31:0] tx_vacancy_offset_p   = 32'h0000_0000,
  parameter logic [31:0] tx_data_offset_p      = 32'h0000_0010,
  parameter logic [31:0] rx_occupancy_offset_p = 32'h0000_0018,
  parameter logic [31:0] rx_data_offset_p      = 32'h0000_001C,
  parameter int          timeout_p             = 1024
) (
  input  logic           clk_i,
  input  logic           reset_n_i,
  output logic [110:0]   m_axil_bus_o,
  input  logic [40:0]    m_axil_bus_i,
  input  logic           tx_v_i,
  input  logic [127:0]   tx_data_i,
  output logic           tx_ready_o,
  output logic           rx_v_o,
  output logic [127:0]   rx_data_o,
  input  logic           rx_yumi_i,
  output logic           err_o
);
  typedef enum logic [2:0] {IDLE, TX_POLL, TX_WR, RX_POLL, RX_RD, RX_OUT} state_e;
  state_e state, state_n;
  logic arv, awv, wv, busy, pri_tx, tmo;
  logic [1:0] cnt;
  logic [127:0] data;
  logic awready, wready, bvalid, arready, rvalid;
  logic [1:0] bresp, rresp;
  logic [31:0] rdata, araddr;
  logic rready, bready, xfer, issue, done, resp_err;
  assign {awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid} = m_axil_bus_i;
  assign rready = state inside {TX_POLL, RX_POLL, RX_RD};
  assign bready = state == TX_WR;
  assign araddr = axil_base_addr_p + (state == TX_POLL ? tx_vacancy_offset_p :
                                      state == RX_POLL ? rx_occupancy_offset_p : rx_data_offset_p);
  assign m_axil_bus_o = {axil_base_addr_p + tx_data_offset_p, 3'b000, awv,
                         data[{cnt, 5'd0} +: 32], 4'hF, wv, bready,
                         araddr, 3'b000, arv, rready};
  // busy spans issue to response, so at most one AXI transaction is ever in flight
  assign xfer = state inside {TX_POLL, TX_WR, RX_POLL, RX_RD};
  assign issue = xfer & ~busy;
  assign done = busy & (bready ? bvalid : rvalid);
  assign resp_err = done & ((bready ? bresp : rresp) != 2'b00);
  assign tx_ready_o = (state == TX_POLL) & done & (rdata >= 32'd4) & tx_v_i;
  assign rx_v_o = state == RX_OUT;
  assign rx_data_o = data;
`ifdef BSG_MCL_HOST_TIMEOUT_EN
  logic [31:0] timer;
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) timer <= '0;
    else timer <= issue ? '0 : timer + {31'b0, busy};
  assign tmo = busy & ~done & (timer >= 32'(timeout_p - 1));
`else
  assign tmo = 1'b0;
`endif
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = (tx_v_i & pri_tx) ? TX_POLL : RX_POLL;
      TX_POLL: if (done) state_n = tx_ready_o ? TX_WR : IDLE;
      TX_WR:   if (done & cnt == 2'd3) state_n = IDLE;
      RX_POLL: if (done) state_n = (rdata >= 32'd4) ? RX_RD : IDLE;
      RX_RD:   if (done & cnt == 2'd3) state_n = RX_OUT;
      RX_OUT:  if (rx_yumi_i) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (tmo) state_n = IDLE;
  end
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      state  <= IDLE;
      arv    <= 1'b0;
      awv    <= 1'b0;
      wv     <= 1'b0;
      busy   <= 1'b0;
      pri_tx <= 1'b1;
      cnt    <= 2'd0;
      data   <= '0;
      err_o  <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= issue | (busy & ~done & ~tmo);
      arv   <= ~tmo & ((issue & state != TX_WR) | (arv & ~arready));
      awv   <= ~tmo & ((issue & state == TX_WR) | (awv & ~awready));
      wv    <= ~tmo & ((issue & state == TX_WR) | (wv & ~wready));
      err_o <= err_o | resp_err | tmo;
      cnt   <= tmo ? 2'd0 : cnt + {1'b0, done & (state == TX_WR | state == RX_RD)};
      if (state == IDLE) pri_tx <= state_n == RX_POLL;
      if (tx_ready_o) data <= tx_data_i;
      else if (done & state == RX_RD) data[{cnt, 5'd0} +: 32] <= rdata;
    end
endmodule

// File: tb/tb_bsg_mcl_axil_host_master.sv
// tb_bsg_mcl_axil_host_master: bench with a reactive AXI-Lite bridge model and packet-level expectations.
module tb_bsg_mcl_axil_host_master;
  localparam logic [31:0] BASE = 32'hFFFF_FFF8;
  localparam logic [31:0] VAC  = BASE + 32'h00;
  localparam logic [31:0] TXD  = BASE + 32'h10;
  localparam logic [31:0] OCC  = BASE + 32'h18;
  localparam logic [31:0] RXD  = BASE + 32'h1C;
  localparam int TO = 64;

  logic clk = 0, rst_n = 0;
  logic [110:0] mosi;
  logic [40:0] miso;
  logic tx_v = 0, tx_ready, rx_v, rx_yumi = 0, err;
  logic [127:0] tx_data = '0, rx_data;

  always #5 clk = ~clk;

  bsg_mcl_axil_host_master #(.axil_base_addr_p(BASE), .timeout_p(TO)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .m_axil_bus_o(mosi), .m_axil_bus_i(miso),
    .tx_v_i(tx_v), .tx_data_i(tx_data), .tx_ready_o(tx_ready),
    .rx_v_o(rx_v), .rx_data_o(rx_data), .rx_yumi_i(rx_yumi), .err_o(err));

  logic [31:0] awaddr, wdata, araddr;
  logic [3:0] wstrb;
  logic awvalid, wvalid, bready, arvalid, rready;
  assign awaddr = mosi[110:79];
  assign awvalid = mosi[75];
  assign wdata = mosi[74:43];
  assign wstrb = mosi[42:39];
  assign wvalid = mosi[38];
  assign bready = mosi[37];
  assign araddr = mosi[36:5];
  assign arvalid = mosi[1];
  assign rready = mosi[0];

  // bridge model state, written only by the control sequence
  logic [31:0] vacancy = 0, occupancy = 0, rxseed = 0;
  int rerr_at = -1;
  bit b_hold = 0;

  function automatic logic [31:0] rx_word(input int n);
    return rxseed ^ (32'(n) * 32'h9E37_79B9);
  endfunction
  function automatic logic [127:0] rx_exp(input int p);
    return {rx_word(4*p+3), rx_word(4*p+2), rx_word(4*p+1), rx_word(4*p)};
  endfunction

  logic s_arready = 0, s_rvalid = 0, s_awready = 0, s_wready = 0, s_bvalid = 0;
  logic [31:0] s_rdata = 0;
  logic [1:0] s_rresp = 0, s_bresp = 0;
  assign miso = {s_awready, s_wready, s_bresp, s_bvalid, s_arready, s_rdata, s_rresp, s_rvalid};

  bit ar_got = 0, aw_got = 0, w_got = 0;
  logic [31:0] ar_a = 0, aw_a = 0, w_d = 0;
  logic [3:0] w_s = 0;
  int dly = 0, ar_n = 0, wr_n = 0, rd_n = 0;
  logic [31:0] ar_log [0:4095];
  logic [31:0] wa_log [0:1023];
  logic [31:0] wd_log [0:1023];
  logic [3:0]  ws_log [0:1023];

  // logs survive reset so that replays after a reset would be visible
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s_arready <= 0; s_rvalid <= 0; s_awready <= 0; s_wready <= 0; s_bvalid <= 0;
      ar_got <= 0; aw_got <= 0; w_got <= 0; dly <= 0;
    end else begin
      if (s_rvalid) begin
        if (rready) s_rvalid <= 0;
      end else if (ar_got) begin
        if (dly > 0) dly <= dly - 1;
        else begin
          ar_got <= 0; s_rvalid <= 1; s_rresp <= 2'b00;
          if (ar_a == VAC) s_rdata <= vacancy;
          else if (ar_a == OCC) s_rdata <= occupancy;
          else if (ar_a == RXD) begin
            s_rdata <= rx_word(rd_n);
            s_rresp <= (rd_n == rerr_at) ? 2'b10 : 2'b00;
            rd_n <= rd_n + 1;
          end else begin
            s_rdata <= 32'hDEAD_BEEF; s_rresp <= 2'b11;
          end
        end
      end
      if (arvalid && s_arready) begin
        ar_got <= 1; ar_a <= araddr; s_arready <= 0; dly <= $urandom_range(0, 2);
        if (ar_n < 4096) ar_log[ar_n] <= araddr;
        ar_n <= ar_n + 1;
      end else if (!ar_got && !s_rvalid) s_arready <= 1'($urandom_range(0, 1));
      if (s_bvalid) begin
        if (bready) s_bvalid <= 0;
      end else if (aw_got && w_got && !b_hold) begin
        s_bvalid <= 1; s_bresp <= 2'b00; aw_got <= 0; w_got <= 0;
        wa_log[wr_n] <= aw_a; wd_log[wr_n] <= w_d; ws_log[wr_n] <= w_s;
        wr_n <= wr_n + 1;
      end
      if (awvalid && s_awready) begin aw_got <= 1; aw_a <= awaddr; s_awready <= 0; end
      else if (!aw_got) s_awready <= 1'($urandom_range(0, 1));
      if (wvalid && s_wready) begin w_got <= 1; w_d <= wdata; w_s <= wstrb; s_wready <= 0; end
      else if (!w_got) s_wready <= 1'($urandom_range(0, 1));
    end

  // protocol monitor: valid/payload held until handshake, no AR overlapping AW/W
  int viol = 0, rdy_n = 0;
  logic p_arv = 0, p_awv = 0, p_wv = 0;
  logic [31:0] p_ara = 0, p_awa = 0, p_wd = 0;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      p_arv = 0; p_awv = 0; p_wv = 0;
    end else begin
      if (p_arv && !(arvalid && araddr == p_ara)) viol++;
      if (p_awv && !(awvalid && awaddr == p_awa)) viol++;
      if (p_wv && !(wvalid && wdata == p_wd)) viol++;
      if (arvalid && (awvalid || wvalid)) viol++;
      if (tx_v && tx_ready) rdy_n++;
      p_arv = arvalid && !s_arready; p_ara = araddr;
      p_awv = awvalid && !s_awready; p_awa = awaddr;
      p_wv = wvalid && !s_wready; p_wd = wdata;
    end

  int checks = 0, errors = 0, rx_pk = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic send(input logic [127:0] d, input string tag);
    bit ok = 0;
    tx_data = d; tx_v = 1;
    for (int i = 0; i < 400 && !ok; i++) begin @(negedge clk); ok = tx_ready; end
    chk({tag, "_accept"}, ok, 1);
    @(posedge clk); #1 tx_v = 0;
  endtask

  task automatic wait_wr(input int n, input string tag);
    for (int i = 0; i < 400 && wr_n < n; i++) @(negedge clk);
    chk({tag, "_writes"}, wr_n >= n, 1);
  endtask

  task automatic check_tx(input int w0, input logic [127:0] d, input string tag);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_addr%0d", tag, k), wa_log[w0+k], TXD);
      chk($sformatf("%s_word%0d", tag, k), wd_log[w0+k], d[32*k +: 32]);
    end
    chk({tag, "_wstrb"}, ws_log[w0], 4'hF);
  endtask

  task automatic recv(input int hold, input string tag);
    bit ok = 0, stable = 1;
    logic [127:0] exp;
    for (int i = 0; i < 400 && !ok; i++) begin @(negedge clk); ok = rx_v; end
    chk({tag, "_valid"}, ok, 1);
    occupancy = 0;
    exp = rx_exp(rx_pk); rx_pk++;
    chk({tag, "_data"}, rx_data, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      stable &= rx_v && (rx_data === exp);
    end
    chk({tag, "_hold"}, stable, 1);
    rx_yumi = 1;
    @(posedge clk); #1 rx_yumi = 0;
    @(negedge clk);
    chk({tag, "_clear"}, rx_v, 0);
  endtask

  task automatic rx_step(input bit rnd);
    rx_yumi = 0;
    if (rx_v && (!rnd || $urandom_range(0, 1) == 1)) begin
      chk("rand_rx_data", rx_data, rx_exp(rx_pk));
      rx_pk++; rx_yumi = 1;
    end
  endtask

  initial begin
    logic [127:0] d;
    logic [127:0] txq [$];
    int w0, r0, a0, a1, nv, consec, rp0;
    bit upd, seen;
    logic [31:0] prev;
    rxseed = $urandom;
    repeat (4) @(negedge clk);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_tx_ready", tx_ready, 0);
    chk("rst_rx_v", rx_v, 0);
    chk("rst_err", err, 0);
    rst_n = 1;

    // basic TX with wrapped address
    vacancy = 8;
    d = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    w0 = wr_n; r0 = rdy_n;
    send(d, "tx");
    wait_wr(w0 + 4, "tx");
    check_tx(w0, d, "tx");
    repeat (5) @(negedge clk);
    chk("tx_ready_once", rdy_n - r0, 1);

    // TX backpressure: vacancy 3 never starts a write, polls alternate with RX
    vacancy = 3; tx_v = 1; tx_data = rand128();
    w0 = wr_n; r0 = rdy_n; a0 = ar_n;
    repeat (60) @(negedge clk);
    chk("bp_no_write", wr_n, w0);
    chk("bp_no_ready", rdy_n, r0);
    nv = 0; consec = 0; prev = 0;
    for (int i = a0; i < ar_n; i++) begin
      if (ar_log[i] == VAC) nv++;
      if (ar_log[i] == VAC && prev == VAC) consec++;
      if (ar_log[i] == VAC || ar_log[i] == OCC) prev = ar_log[i];
    end
    chk("bp_repolls", nv > 2, 1);
    chk("bp_alternate", consec, 0);
    vacancy = 4;
    d = rand128();
    send(d, "bp");
    wait_wr(w0 + 4, "bp");
    check_tx(w0, d, "bp");
    chk("bp_proto", viol, 0);

    // RX packet held without yumi
    occupancy = 4;
    recv(10, "rx");

    // SLVERR on word 2 still delivers the packet
    chk("err_before", err, 0);
    rerr_at = 4 * rx_pk + 2;
    occupancy = 4;
    recv(0, "err_rx");
    chk("err_after", err, 1);

    // randomized mix: TX always pending, RX always available
    vacancy = 8; occupancy = 4; tx_data = rand128(); tx_v = 1; upd = 0;
    w0 = wr_n; a0 = ar_n; rp0 = rx_pk;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (upd) begin tx_data = rand128(); upd = 0; end
      if (tx_ready) begin txq.push_back(tx_data); upd = 1; end
      rx_step(1);
    end
    a1 = ar_n;
    @(posedge clk); #1 tx_v = 0;
    occupancy = 0;
    for (int c = 0; c < 150; c++) begin @(negedge clk); rx_step(0); end
    rx_yumi = 0;
    wait_wr(w0 + 4 * txq.size(), "rand");
    for (int p = 0; p < txq.size(); p++)
      for (int k = 0; k < 4; k++)
        chk($sformatf("rand_tx%0d_w%0d", p, k), wd_log[w0 + 4*p + k], txq[p][32*k +: 32]);
    chk("rand_tx_count", txq.size() >= 3, 1);
    chk("rand_rx_count", rx_pk - rp0 >= 3, 1);
    consec = 0; prev = 0;
    for (int i = a0; i < a1; i++)
      if (ar_log[i] == VAC || ar_log[i] == OCC) begin
        if (ar_log[i] == prev) consec++;
        prev = ar_log[i];
      end
    chk("rand_alternate", consec, 0);
    chk("rand_proto", viol, 0);

    // reset during TX_WR
    vacancy = 8;
    send(rand128(), "rst_tx");
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin @(negedge clk); seen = awvalid; end
    chk("rst_mid_seen", seen, 1);
    #2 rst_n = 0;
    #1;
    chk("rst_mid_awvalid", awvalid, 0);
    chk("rst_mid_wvalid", wvalid, 0);
    chk("rst_mid_arvalid", arvalid, 0);
    chk("rst_mid_err", err, 0);
    repeat (3) @(negedge clk);
    w0 = wr_n; a0 = ar_n;
    rst_n = 1;
    repeat (40) @(negedge clk);
    chk("rst_no_replay", wr_n, w0);
    chk("rst_restart", ar_n > a0, 1);
    chk("rst_polls_rx", ar_log[ar_n - 1], OCC);

`ifdef BSG_MCL_HOST_TIMEOUT_EN
    b_hold = 1;
    send(rand128(), "tmo");
    for (int i = 0; i < TO + 200 && !err; i++) @(negedge clk);
    chk("tmo_err", err, 1);
    repeat (2) @(negedge clk);
    chk("tmo_awvalid", awvalid, 0);
    chk("tmo_wvalid", wvalid, 0);
    chk("tmo_idle_bready", bready, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
